al_time_counter: RTL and testbench
==================================

# al_time_counter

Parametrised successor to the alarm-clock minute counter. It holds wall-clock time as packed BCD HH:MM and advances it from a tick input through an internal prescaler. It supports 12- or 24-hour mode, validates loaded times and flags day rollover. An optional alarm comparator is compiled in by macro. It sits between the frequency divider (tick source) and the display/alarm logic of the alarm clock.

## Interface
- HOUR_MODE, 24: 24 = hours 00–23; 12 = hours 01–12 with AM/PM flag. Any other value is illegal.
- PRESCALE, 1: tick pulses per minute advance, range 1–255.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- one_minute  in  1  tick; sampled every rising edge, level-counted (high for N cycles = N ticks)
- time_in  in  16  BCD HH:MM to load ({H1,H0,M1,M0}, 4 bits each)
- pm_in  in  1  PM flag loaded with time_in; ignored when HOUR_MODE=24
- load_new_time  in  1  load strobe
- alarm_time  in  16  BCD HH:MM alarm setpoint
- alarm_pm  in  1  alarm PM flag; ignored when HOUR_MODE=24
- alarm_en  in  1  alarm enable
- current_time_out  out  16  current BCD time
- pm  out  1  current PM flag; constant 0 when HOUR_MODE=24
- load_error  out  1  one-cycle pulse: rejected load
- day_rollover  out  1  one-cycle pulse: midnight crossed by an advance
- alarm_match  out  1  one-cycle pulse: advance landed on the alarm time

## Operation
- Reset values:
  - HOUR_MODE=24: current_time_out=16'h0000, pm=0.
  - HOUR_MODE=12: current_time_out=16'h1200, pm=0 (midnight).
  - Prescaler=0; load_error, day_rollover and alarm_match all 0.
- Load priority: load_new_time beats one_minute in the same cycle. The tick in that cycle is discarded and the prescaler clears to 0.
- Load validation:
  - Every nibble must be ≤9.
  - M1 must be ≤5.
  - Hours must be 00–23 (24h) or 01–12 (12h).
  - Valid: time, and pm from pm_in, register at the edge.
  - Invalid: time, pm and prescaler are unchanged; load_error pulses.
- Tick handling:
  - If the prescaler equals PRESCALE-1, it clears and the time advances one minute.
  - Otherwise the prescaler increments.
- Advance in 24h mode:
  - M0 wraps 9→0 and carries into M1.
  - M1 wraps 5→0 and carries into the hour.
  - Hour 23 wraps to 00 and pulses day_rollover.
- Advance in 12h mode:
  - 11:59 advances to 12:00 and toggles pm.
  - 12:59 advances to 01:00.
  - 11:59 PM advances to 12:00 AM and pulses day_rollover.
- Alarm (AL_ALARM_EN only):
  - alarm_match pulses when all of these hold: an advance occurs, alarm_en=1, the new time equals alarm_time, and (12h mode only) the new pm equals alarm_pm.
  - A load never raises alarm_match.
- Arithmetic is nibble-wise BCD only. No binary intermediate wider than 4 bits per digit.

## Timing
- All outputs are registered and update on the same edge that samples the causing input. Latency from tick or load to output is 1 edge.
- Status pulses are high for exactly the one cycle following the causing edge, and are 0 otherwise.
- Asserting reset mid-count clears time, pm, prescaler and pulses immediately, without waiting for a clock edge. Deassertion is synchronised externally; the first tick is counted on the first edge after release.
- Back-to-back ticks on consecutive cycles each count. There is no edge detection.
- Simultaneous invalid load and tick: load_error pulses, the tick is discarded, and time is unchanged.

## Configuration
- AL_ALARM_EN:
  - Defined: the comparator and alarm_match logic are built.
  - Undefined: the alarm ports remain, alarm_time, alarm_pm and alarm_en are ignored, alarm_match is tied 0, and no comparator is synthesised.

## Test plan
- Release reset, load 16'h1236 with HOUR_MODE=24, PRESCALE=1, then 12 single-cycle ticks -> outputs 1236 then 1237…1248. load_error stays 0.
- Load 16'h2358, 2 ticks -> 2359, then 0000 with day_rollover high exactly one cycle.
- HOUR_MODE=12:
  - Load 1159 pm_in=0, tick -> 1200 pm=1.
  - Load 1259 pm_in=1, tick -> 0100 pm=1.
  - Load 1159 pm_in=1, tick -> 1200 pm=0 with day_rollover.
- Load each of 16'h2400, 16'h1260, 16'h1A00 and 16'heeee (24h), plus 16'h0000 (12h) -> load_error pulse each time, time unchanged. Load 16'h1630 together with a tick -> 1630, prescaler cleared.
- PRESCALE=4, load 0000: 3 ticks -> 0000, 4th tick -> 0001. Assert reset after the 2nd of a further 4 ticks -> 0000 asynchronously; after release, 4 ticks are required to reach 0001.
- AL_ALARM_EN defined, alarm_time=16'h0630, alarm_en=1: load 0629, tick -> 0630 with alarm_match pulse. Load 0630 directly -> no pulse. With alarm_en=0, or the macro undefined -> never pulses.

Source files
------------

// File: rtl/al_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : al_time_counter
// Description : Packed-BCD HH:MM wall clock advanced by a prescaled minute
//               tick, 12/24-hour modes, load validation, day-rollover pulse.
//               Optional alarm comparator built when AL_ALARM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module al_time_counter #(
    parameter int HOUR_MODE = 24,
    parameter int PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        one_minute,
    input  logic [15:0] time_in,
    input  logic        pm_in,
    input  logic        load_new_time,
    input  logic [15:0] alarm_time,
    input  logic        alarm_pm,
    input  logic        alarm_en,
    output logic [15:0] current_time_out,
    output logic        pm,
    output logic        load_error,
    output logic        day_rollover,
    output logic        alarm_match
);

    localparam bit          c_MODE12     = (HOUR_MODE == 12);
    localparam logic [7:0]  c_PRE_MAX    = 8'(PRESCALE - 1);
    localparam logic [15:0] c_RESET_TIME = c_MODE12 ? 16'h1200 : 16'h0000;

    generate
        if (HOUR_MODE != 12 && HOUR_MODE != 24) begin : g_bad_hour_mode
            $error("al_time_counter: HOUR_MODE must be 12 or 24");
        end
        if (PRESCALE < 1 || PRESCALE > 255) begin : g_bad_prescale
            $error("al_time_counter: PRESCALE must be 1..255");
        end
    endgenerate

    logic [15:0] r_time;
    logic        r_pm;
    logic [7:0]  r_presc;
    logic        r_load_error;
    logic        r_day_rollover;

    logic [15:0] w_next_time;
    logic        w_next_pm;
    logic        w_wrap_day;
    logic        w_load_ok;
    logic        w_advance;

    // Minute increment, digit by digit with explicit carries.
    always_comb begin
        w_next_time = r_time;
        w_next_pm   = r_pm;
        w_wrap_day  = 1'b0;
        if (r_time[3:0] != 4'd9) begin
            w_next_time[3:0] = r_time[3:0] + 4'd1;
        end else begin
            w_next_time[3:0] = 4'd0;
            if (r_time[7:4] != 4'd5) begin
                w_next_time[7:4] = r_time[7:4] + 4'd1;
            end else begin
                w_next_time[7:4] = 4'd0;
                if (c_MODE12 && r_time[15:8] == 8'h11) begin
                    // Noon/midnight: the day ends on the PM->AM transition.
                    w_next_time[15:8] = 8'h12;
                    w_next_pm         = ~r_pm;
                    w_wrap_day        = r_pm;
                end else if (c_MODE12 && r_time[15:8] == 8'h12) begin
                    w_next_time[15:8] = 8'h01;
                end else if (!c_MODE12 && r_time[15:8] == 8'h23) begin
                    w_next_time[15:8] = 8'h00;
                    w_wrap_day        = 1'b1;
                end else if (r_time[11:8] == 4'd9) begin
                    w_next_time[15:12] = r_time[15:12] + 4'd1;
                    w_next_time[11:8]  = 4'd0;
                end else begin
                    w_next_time[11:8] = r_time[11:8] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_load_ok = (time_in[15:12] <= 4'd9) && (time_in[11:8] <= 4'd9) &&
                    (time_in[7:4]   <= 4'd5) && (time_in[3:0]  <= 4'd9);
        if (c_MODE12) begin
            w_load_ok = w_load_ok &&
                        (((time_in[15:12] == 4'd0) && (time_in[11:8] != 4'd0)) ||
                         ((time_in[15:12] == 4'd1) && (time_in[11:8] <= 4'd2)));
        end else begin
            w_load_ok = w_load_ok &&
                        ((time_in[15:12] <= 4'd1) ||
                         ((time_in[15:12] == 4'd2) && (time_in[11:8] <= 4'd3)));
        end
    end

    assign w_advance = !load_new_time && one_minute && (r_presc == c_PRE_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_time         <= c_RESET_TIME;
            r_pm           <= 1'b0;
            r_presc        <= 8'd0;
            r_load_error   <= 1'b0;
            r_day_rollover <= 1'b0;
        end else begin
            r_load_error   <= 1'b0;
            r_day_rollover <= 1'b0;
            if (load_new_time) begin
                if (w_load_ok) begin
                    r_time  <= time_in;
                    r_pm    <= c_MODE12 ? pm_in : 1'b0;
                    r_presc <= 8'd0;
                end else begin
                    r_load_error <= 1'b1;
                end
            end else if (one_minute) begin
                if (w_advance) begin
                    r_presc        <= 8'd0;
                    r_time         <= w_next_time;
                    r_pm           <= w_next_pm;
                    r_day_rollover <= w_wrap_day;
                end else begin
                    r_presc <= r_presc + 8'd1;
                end
            end
        end
    end

`ifdef AL_ALARM_EN
    logic r_alarm_match;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_alarm_match <= 1'b0;
        end else begin
            r_alarm_match <= w_advance && alarm_en && (w_next_time == alarm_time) &&
                             (!c_MODE12 || (w_next_pm == alarm_pm));
        end
    end

    assign alarm_match = r_alarm_match;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = ^{alarm_time, alarm_pm, alarm_en};
    assign alarm_match    = 1'b0;
`endif

    assign current_time_out = r_time;
    assign pm               = r_pm;
    assign load_error       = r_load_error;
    assign day_rollover     = r_day_rollover;

endmodule
`default_nettype wire

// File: tb/tb_al_time_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_al_time_counter
// Description : Directed scoreboard bench for al_time_counter: 24h, 12h and
//               prescaled instances sharing clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_al_time_counter;

    logic        clk;
    logic        reset;
    logic [15:0] time_in;
    logic        pm_in;
    logic [15:0] alarm_time;
    logic        alarm_pm;
    logic        alarm_en;
    logic        ld  [3];
    logic        tk  [3];
    logic [15:0] cur [3];
    logic        pmo [3];
    logic        le  [3];
    logic        dr  [3];
    logic        am  [3];

    int checks   = 0;
    int failures = 0;

`ifdef AL_ALARM_EN
    localparam logic c_AL = 1'b1;
`else
    localparam logic c_AL = 1'b0;
`endif

    typedef struct {
        int          sel;
        string       tag;
        logic [15:0] t;
        logic        pm;
        logic        le;
        logic        dr;
        logic        am;
    } exp_t;

    exp_t sbq[$];

    al_time_counter #(.HOUR_MODE(24), .PRESCALE(1)) u_h24 (
        .clk(clk), .reset(reset), .one_minute(tk[0]), .time_in(time_in), .pm_in(pm_in),
        .load_new_time(ld[0]), .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_en(alarm_en),
        .current_time_out(cur[0]), .pm(pmo[0]), .load_error(le[0]), .day_rollover(dr[0]),
        .alarm_match(am[0]));

    al_time_counter #(.HOUR_MODE(12), .PRESCALE(1)) u_h12 (
        .clk(clk), .reset(reset), .one_minute(tk[1]), .time_in(time_in), .pm_in(pm_in),
        .load_new_time(ld[1]), .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_en(alarm_en),
        .current_time_out(cur[1]), .pm(pmo[1]), .load_error(le[1]), .day_rollover(dr[1]),
        .alarm_match(am[1]));

    al_time_counter #(.HOUR_MODE(24), .PRESCALE(4)) u_p4 (
        .clk(clk), .reset(reset), .one_minute(tk[2]), .time_in(time_in), .pm_in(pm_in),
        .load_new_time(ld[2]), .alarm_time(alarm_time), .alarm_pm(alarm_pm), .alarm_en(alarm_en),
        .current_time_out(cur[2]), .pm(pmo[2]), .load_error(le[2]), .day_rollover(dr[2]),
        .alarm_match(am[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference minute increment through decimal arithmetic (24h only).
    function automatic logic [15:0] plus_one_min(input logic [15:0] t);
        int h;
        int m;
        h = int'(t[15:12]) * 10 + int'(t[11:8]);
        m = int'(t[7:4]) * 10 + int'(t[3:0]) + 1;
        if (m == 60) begin
            m = 0;
            h = (h + 1) % 24;
        end
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check_now(input int s, input string tag, input logic [15:0] et,
                             input logic epm, input logic ele, input logic edr, input logic eam);
        chk({tag, ".time"}, 32'(cur[s]), 32'(et));
        chk({tag, ".pm"},   32'(pmo[s]), 32'(epm));
        chk({tag, ".lerr"}, 32'(le[s]),  32'(ele));
        chk({tag, ".roll"}, 32'(dr[s]),  32'(edr));
        chk({tag, ".alrm"}, 32'(am[s]),  32'(eam));
    endtask

    // Drive one cycle of stimulus on instance s, queue the expectation, check after the edge.
    task automatic drive(input int s, input logic l, input logic t, input logic [15:0] tin,
                         input logic pin, input string tag, input logic [15:0] et,
                         input logic epm, input logic ele, input logic edr, input logic eam);
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            ld[i] = 1'b0;
            tk[i] = 1'b0;
        end
        ld[s]   = l;
        tk[s]   = t;
        time_in = tin;
        pm_in   = pin;
        e.sel = s; e.tag = tag; e.t = et; e.pm = epm; e.le = ele; e.dr = edr; e.am = eam;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            check_now(e.sel, e.tag, e.t, e.pm, e.le, e.dr, e.am);
        end
    endtask

    initial begin
        logic [15:0] m;
        reset      = 1'b0;
        time_in    = 16'h0000;
        pm_in      = 1'b0;
        alarm_time = 16'h0630;
        alarm_pm   = 1'b0;
        alarm_en   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ld[i] = 1'b0;
            tk[i] = 1'b0;
        end
        #12;
        check_now(0, "rst24", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now(1, "rst12", 16'h1200, 1'b0, 1'b0, 1'b0, 1'b0);
        check_now(2, "rstp4", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 reset = 1'b1;

        // 24h counting and day rollover
        drive(0, 1, 0, 16'h1236, 0, "ld1236", 16'h1236, 0, 0, 0, 0);
        m = 16'h1236;
        for (int i = 0; i < 12; i++) begin
            m = plus_one_min(m);
            drive(0, 0, 1, 16'h0000, 0, "tick24", m, 0, 0, 0, 0);
        end
        drive(0, 1, 0, 16'h2358, 0, "ld2358", 16'h2358, 0, 0, 0, 0);
        drive(0, 0, 1, 16'h0000, 0, "to2359", 16'h2359, 0, 0, 0, 0);
        drive(0, 0, 1, 16'h0000, 0, "midnt24", 16'h0000, 0, 0, 1, 0);
        drive(0, 0, 0, 16'h0000, 0, "idle24", 16'h0000, 0, 0, 0, 0);
        drive(0, 0, 1, 16'h0000, 0, "to0001", 16'h0001, 0, 0, 0, 0);

        // 12h transitions
        drive(1, 1, 0, 16'h1159, 0, "ld1159a", 16'h1159, 0, 0, 0, 0);
        drive(1, 0, 1, 16'h0000, 0, "noon", 16'h1200, 1, 0, 0, 0);
        drive(1, 1, 0, 16'h1259, 1, "ld1259p", 16'h1259, 1, 0, 0, 0);
        drive(1, 0, 1, 16'h0000, 0, "to0100p", 16'h0100, 1, 0, 0, 0);
        drive(1, 1, 0, 16'h1159, 1, "ld1159p", 16'h1159, 1, 0, 0, 0);
        drive(1, 0, 1, 16'h0000, 0, "midnt12", 16'h1200, 0, 0, 1, 0);
        drive(1, 0, 0, 16'h0000, 0, "idle12", 16'h1200, 0, 0, 0, 0);
        drive(1, 1, 0, 16'h0959, 0, "ld0959", 16'h0959, 0, 0, 0, 0);
        drive(1, 0, 1, 16'h0000, 0, "to1000", 16'h1000, 0, 0, 0, 0);

        // Rejected loads leave time untouched
        drive(0, 1, 0, 16'h1015, 0, "ld1015", 16'h1015, 0, 0, 0, 0);
        drive(0, 1, 0, 16'h2400, 0, "bad2400", 16'h1015, 0, 1, 0, 0);
        drive(0, 0, 0, 16'h0000, 0, "lerrclr", 16'h1015, 0, 0, 0, 0);
        drive(0, 1, 0, 16'h1260, 0, "bad1260", 16'h1015, 0, 1, 0, 0);
        drive(0, 1, 0, 16'h1A00, 0, "bad1A00", 16'h1015, 0, 1, 0, 0);
        drive(0, 1, 0, 16'heeee, 0, "badeeee", 16'h1015, 0, 1, 0, 0);
        drive(0, 1, 1, 16'h2400, 0, "badtick", 16'h1015, 0, 1, 0, 0);
        drive(0, 1, 0, 16'h2359, 0, "ld2359", 16'h2359, 0, 0, 0, 0);
        drive(1, 1, 0, 16'h0000, 1, "bad0000", 16'h1000, 0, 1, 0, 0);
        drive(1, 1, 0, 16'h1300, 0, "bad1300", 16'h1000, 0, 1, 0, 0);

        // Prescaler of 4, load-with-tick, asynchronous reset
        drive(2, 1, 0, 16'h0000, 0, "p4ld", 16'h0000, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(2, 0, 1, 16'h0000, 0, "p4hold", 16'h0000, 0, 0, 0, 0);
        drive(2, 0, 1, 16'h0000, 0, "p4adv", 16'h0001, 0, 0, 0, 0);
        drive(2, 0, 1, 16'h0000, 0, "p4pre1", 16'h0001, 0, 0, 0, 0);
        drive(2, 0, 1, 16'h0000, 0, "p4pre2", 16'h0001, 0, 0, 0, 0);
        drive(2, 1, 1, 16'h1630, 0, "ldtick", 16'h1630, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(2, 0, 1, 16'h0000, 0, "p4clr", 16'h1630, 0, 0, 0, 0);
        drive(2, 0, 1, 16'h0000, 0, "p4to1631", 16'h1631, 0, 0, 0, 0);
        drive(2, 0, 1, 16'h0000, 0, "p4r1", 16'h1631, 0, 0, 0, 0);
        drive(2, 0, 1, 16'h0000, 0, "p4r2", 16'h1631, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check_now(2, "arstp4", 16'h0000, 0, 0, 0, 0);
        check_now(1, "arst12", 16'h1200, 0, 0, 0, 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(2, 0, 1, 16'h0000, 0, "postrst", 16'h0000, 0, 0, 0, 0);
        drive(2, 0, 1, 16'h0000, 0, "postadv", 16'h0001, 0, 0, 0, 0);

        // Alarm comparator
        alarm_time = 16'h0630;
        alarm_pm   = 1'b1;
        alarm_en   = 1'b1;
        drive(0, 1, 0, 16'h0629, 0, "al_ld", 16'h0629, 0, 0, 0, 0);
        drive(0, 0, 1, 16'h0000, 0, "al_hit", 16'h0630, 0, 0, 0, c_AL);
        drive(0, 0, 0, 16'h0000, 0, "al_clr", 16'h0630, 0, 0, 0, 0);
        drive(0, 1, 0, 16'h0630, 0, "al_load", 16'h0630, 0, 0, 0, 0);
        drive(0, 0, 1, 16'h0000, 0, "al_past", 16'h0631, 0, 0, 0, 0);
        drive(1, 1, 0, 16'h0629, 0, "al12ld_a", 16'h0629, 0, 0, 0, 0);
        drive(1, 0, 1, 16'h0000, 0, "al12_pmx", 16'h0630, 0, 0, 0, 0);
        drive(1, 1, 0, 16'h0629, 1, "al12ld_p", 16'h0629, 1, 0, 0, 0);
        drive(1, 0, 1, 16'h0000, 0, "al12_hit", 16'h0630, 1, 0, 0, c_AL);
        alarm_en = 1'b0;
        drive(0, 1, 0, 16'h0629, 0, "al_offld", 16'h0629, 0, 0, 0, 0);
        drive(0, 0, 1, 16'h0000, 0, "al_off", 16'h0630, 0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
